// File: rtl/seq_detector_prog.sv
// seq_detector_prog: programmable serial pattern detector, Mealy match, registered copy, saturating count.
// Revision 1.0 - initial release.
`default_nettype none

module seq_detector_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'h09,
  parameter int                 DEF_LEN     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               din_valid,
  input  logic               enable,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic               match_q,
  output logic [CNT_W-1:0]   match_count
);

  // hist holds the last MAX_LEN-1 accepted bits; din completes the window
  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;

  logic               acc;
  logic [MAX_LEN-1:0] win;
  logic [MAX_LEN-1:0] mask;
  logic               fill_ok;
  logic               win_eq;
  logic               cfg_ok;

  assign acc = din_valid & enable & ~cfg_load;
  assign win = {hist, din};

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
    assign mask[i] = (LEN_W'(i) < len);
  end

  assign fill_ok = (fill >= (len - LEN_W'(1)));
  assign win_eq  = (((win ^ pattern) & mask) == '0);
  assign match   = rst & acc & fill_ok & win_eq;
  assign cfg_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist    <= '0;
      fill    <= '0;
      pattern <= DEF_PATTERN;
      len     <= LEN_W'(DEF_LEN);
      overlap <= 1'b1;
    end else if (cfg_load) begin
      if (cfg_ok) begin
        pattern <= cfg_pattern;
        len     <= cfg_len;
        overlap <= cfg_overlap;
        hist    <= '0;
        fill    <= '0;
      end
    end else if (acc) begin
      if (match && !overlap) begin
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= win[MAX_LEN-2:0];
        if (fill != LEN_W'(MAX_LEN)) begin
          fill <= fill + LEN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_q     <= 1'b0;
      match_count <= '0;
    end else begin
      match_q <= match;
      if (cnt_clr) begin
        match_count <= '0;
      end else if (match && (match_count != '1)) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: directed self-checking bench for seq_detector_prog (CNT_W=2 to reach saturation).
// Revision 1.0 - initial release.
`default_nettype none

module tb_seq_detector_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               din = 1'b0;
  logic               din_valid = 1'b0;
  logic               enable = 1'b1;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               cnt_clr = 1'b0;
  logic               match;
  logic               match_q;
  logic [CNT_W-1:0]   match_count;

  int n_cmp = 0;
  int n_bad = 0;

  seq_detector_prog #(
    .MAX_LEN    (MAX_LEN),
    .LEN_W      (LEN_W),
    .CNT_W      (CNT_W),
    .DEF_PATTERN(8'h09),
    .DEF_LEN    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .enable     (enable),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cnt_clr    (cnt_clr),
    .match      (match),
    .match_q    (match_q),
    .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One valid sample: match checked mid-cycle, match_q checked after the edge
  task automatic send(input logic b, input logic exp);
    @(negedge clk);
    din       = b;
    din_valid = 1'b1;
    #1 check("match", match, exp);
    @(posedge clk);
    #1 check("match_q", match_q, exp);
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      din = 1'($urandom_range(0, 1));
      #1 check("idle_match", match, 1'b0);
    end
  endtask

  // Bits sent MSB first; exp bit for each sample uses the same indexing
  task automatic stream(input logic [15:0] bits, input logic [15:0] exp, input int n, input int gap_max);
    for (int k = n - 1; k >= 0; k--) begin
      send(bits[k], exp[k]);
      if (gap_max > 0) idle($urandom_range(1, gap_max));
    end
  endtask

  // A sample is presented alongside the load; it must never match
  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov);
    @(negedge clk);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    din         = 1'b1;
    din_valid   = 1'b1;
    #1 check("load_match", match, 1'b0);
    @(posedge clk);
    #1 cfg_load = 1'b0;
    din_valid   = 1'b0;
  endtask

  task automatic clear_count();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    check("cnt_clr", match_count, 0);
  endtask

  initial begin
    // Reset state, with a valid sample presented during reset
    din       = 1'b1;
    din_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("rst_match", match, 1'b0);
    check("rst_match_q", match_q, 1'b0);
    check("rst_count", match_count, 0);
    @(negedge clk);
    din_valid = 1'b0;
    rst       = 1'b1;

    // Default 1001 overlapping
    stream(16'h0049, 16'h0009, 7, 0);
    check("t1_count", match_count, 2);

    // Non-overlapping
    clear_count();
    load(8'h09, 4'd4, 1'b0);
    stream(16'h0049, 16'h0008, 7, 0);
    check("t2_count", match_count, 1);

    // Valid gaps are invisible; upper pattern bits are don't-care
    load(8'hF9, 4'd4, 1'b1);
    clear_count();
    stream(16'h0049, 16'h0009, 7, 3);
    check("t3_count", match_count, 2);

    // Illegal lengths leave the overlapping 1001 config in place
    load(8'h09, 4'd4, 1'b1);
    load(8'h06, 4'd0, 1'b0);
    load(8'h06, 4'd9, 1'b0);
    clear_count();
    stream(16'h0049, 16'h0009, 7, 0);
    check("t4_count", match_count, 2);

    // Sample during cfg_load is dropped: 1,0,0 then load (with din=1) clears history
    stream(16'h0004, 16'h0000, 3, 0);
    load(8'h09, 4'd4, 1'b1);
    send(1'b1, 1'b0);

    // enable=0 holds history: 1,0,0 [1 ignored] 1 -> match
    load(8'h09, 4'd4, 1'b1);
    stream(16'h0004, 16'h0000, 3, 0);
    enable = 1'b0;
    send(1'b1, 1'b0);
    enable = 1'b1;
    send(1'b1, 1'b1);

    // Length 1 and length MAX_LEN boundaries
    load(8'h01, 4'd1, 1'b1);
    stream(16'h0005, 16'h0005, 3, 0);
    load(8'hA5, 4'd8, 1'b0);
    stream(16'h00A5, 16'h0001, 8, 0);
    stream(16'h00A5, 16'h0001, 8, 0);

    // Saturation at 3 with CNT_W=2
    load(8'h09, 4'd4, 1'b1);
    clear_count();
    stream(16'h0009, 16'h0001, 4, 0);
    check("sat1", match_count, 1);
    stream(16'h0001, 16'h0001, 3, 0);
    check("sat2", match_count, 2);
    stream(16'h0001, 16'h0001, 3, 0);
    check("sat3", match_count, 3);
    stream(16'h0001, 16'h0001, 3, 0);
    check("sat4", match_count, 3);
    stream(16'h0001, 16'h0001, 3, 0);
    check("sat5", match_count, 3);

    // cnt_clr wins over a coinciding match
    stream(16'h0000, 16'h0000, 2, 0);
    cnt_clr = 1'b1;
    send(1'b1, 1'b1);
    cnt_clr = 1'b0;
    check("clr_on_match", match_count, 0);

    // Async reset mid-pattern after 1,0,0
    load(8'h00, 4'd2, 1'b0);
    load(8'h09, 4'd4, 1'b1);
    stream(16'h0004, 16'h0000, 3, 0);
    @(negedge clk);
    din       = 1'b1;
    din_valid = 1'b1;
    #1 rst = 1'b0;
    #1 check("arst_match", match, 1'b0);
    check("arst_match_q", match_q, 1'b0);
    check("arst_count", match_count, 0);
    @(negedge clk);
    din_valid = 1'b0;
    rst       = 1'b1;
    // Pre-reset 1,0,0 is forgotten: first 1 cannot match; 1,0,0,1 then matches, and 0,0,1 overlaps
    stream(16'h0049, 16'h0009, 7, 0);
    check("t6_count", match_count, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
